if_id_fetch_stage: RTL and testbench

- Fetch stage sitting directly downstream of the program counter register.
- Takes the current PC, issues one instruction-memory read per PC over a valid/ready request channel, and waits for the response.
- Writes `{pc, instruction, valid}` into the IF/ID pipeline register.
- Drives the PC's stall input so the PC advances only when an instruction has been committed to IF/ID, or on a flush.

---
 rtl/if_id_fetch_stage.sv | 102 ++++++++++
 tb/tb_if_id_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: issues one instruction-memory read per PC and fills the IF/ID register.
// Controls the PC stall so the PC only moves when IF/ID is loaded or on a flush.
module if_id_fetch_stage #(
  parameter int unsigned    XLEN = 64,
  parameter int unsigned    ILEN = 32,
  parameter logic [ILEN-1:0] NOP = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            stall,
  input  logic            flush,
  output logic            pc_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instr
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e          state_q;
  logic [XLEN-1:0] req_pc_q;
  logic [ILEN-1:0] hold_instr_q;
  logic            advance;
  logic [ILEN-1:0] advance_instr;

  always_comb begin
    imem_req_valid = reset && (state_q == StReq) && !flush;
    imem_req_addr  = pc_in;
    advance        = 1'b0;
    if (reset && !flush && !stall) begin
      advance = ((state_q == StWait) && imem_rsp_valid) || (state_q == StHold);
    end
    advance_instr = (state_q == StWait) ? imem_rsp_data : hold_instr_q;
    // PC is held throughout reset, even if a flush is asserted.
    pc_stall = !reset || !(advance || flush);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StReq;
      req_pc_q     <= '0;
      hold_instr_q <= NOP;
      if_id_valid  <= 1'b0;
      if_id_pc     <= '0;
      if_id_instr  <= NOP;
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_req_valid && imem_req_ready) begin
            req_pc_q <= pc_in;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= imem_rsp_valid ? StReq : StDrain;
          end else if (imem_rsp_valid) begin
            if (stall) begin
              hold_instr_q <= imem_rsp_data;
              state_q      <= StHold;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StHold: begin
          if (flush || !stall) begin
            state_q <= StReq;
          end
        end
        StDrain: begin
          // Response for the flushed request is swallowed here.
          if (imem_rsp_valid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase

      if (flush) begin
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
        if_id_instr <= NOP;
      end else if (advance) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc_q;
        if_id_instr <= advance_instr;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
        if_id_instr <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: expected IF/ID loads are queued by the stimulus
// and consumed by a monitor; control outputs are checked inline.
module tb_if_id_fetch_stage;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic            pc_stall;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b0;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [ILEN-1:0] if_id_instr;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  if_id_fetch_stage #(.XLEN(XLEN), .ILEN(ILEN), .NOP(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .stall          (stall),
    .flush          (flush),
    .pc_stall       (pc_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A valid IF/ID after an edge with stall low is a fresh load; with stall high it is a hold.
  always @(posedge clk) begin
    logic st;
    exp_t e;
    st = stall;
    #1;
    if (reset && if_id_valid && !st) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got pc %h instr %h expected none", if_id_pc, if_id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("load_pc", if_id_pc, e.pc);
        chk("load_instr", {32'h0, if_id_instr}, {32'h0, e.instr});
      end
    end
  end

  task automatic fetch1(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins);
    @(negedge clk);
    pc_in = pc; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    #1;
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, pc);
    chk("pc_stall_req", pc_stall, 1);
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = ins;
    exp_q.push_back({pc, ins});
    #1;
    chk("pc_stall_load", pc_stall, 0);
    chk("bubble_valid", if_id_valid, 0);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_pc_stall", pc_stall, 1);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_req_valid", imem_req_valid, 1);

    // Single-cycle memory stream
    fetch1(64'h0, 32'h0000_0A0A);
    fetch1(64'h4, 32'h0000_0B0B);
    fetch1(64'h8, 32'h0000_0C0C);

    // Memory not ready for 3 cycles at 0x100
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_in = 64'h100; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      #1;
      chk("bp_req_valid", imem_req_valid, 1);
      chk("bp_req_addr", imem_req_addr, 64'h100);
      chk("bp_pc_stall", pc_stall, 1);
      if (i > 0) chk("bp_if_id_valid", if_id_valid, 0);
    end
    fetch1(64'h100, 32'h1234_5678);

    // Response during a 2-cycle decode stall
    @(negedge clk);
    pc_in = 64'h20; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDDDD_0001; stall = 1'b1;
    #1;
    chk("stall_rsp_pc_stall", pc_stall, 1);
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("hold_no_req", imem_req_valid, 0);
    chk("hold_pc_stall", pc_stall, 1);
    chk("hold_if_id_valid", if_id_valid, 0);
    @(negedge clk);
    stall = 1'b0; imem_req_ready = 1'b0;
    exp_q.push_back({64'h20, 32'hDDDD_0001});
    #1;
    chk("hold_release_pc_stall", pc_stall, 0);
    chk("hold_release_no_req", imem_req_valid, 0);
    @(negedge clk);
    #1;
    chk("hold_loaded_valid", if_id_valid, 1);

    // Flush in WAIT, late response drained
    @(negedge clk);
    pc_in = 64'h30; imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_wait_pc_stall", pc_stall, 0);
    chk("flush_wait_req", imem_req_valid, 0);
    @(negedge clk);
    flush = 1'b0; pc_in = 64'h400; imem_req_ready = 1'b1;
    #1;
    chk("drain_no_req", imem_req_valid, 0);
    chk("drain_pc_stall", pc_stall, 1);
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_AD00;
    #1;
    chk("drain_rsp_pc_stall", pc_stall, 1);
    fetch1(64'h400, 32'hEEEE_0002);

    // Flush with response and stall together
    @(negedge clk);
    pc_in = 64'h500; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; stall = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_0003; flush = 1'b1;
    #1;
    chk("flush_stall_held_valid", if_id_valid, 1);
    chk("flush_stall_pc_stall", pc_stall, 0);
    @(negedge clk);
    flush = 1'b0; stall = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("flush_valid", if_id_valid, 0);
    chk("flush_pc", if_id_pc, 0);
    chk("flush_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    chk("flush_back_to_req", imem_req_valid, 1);

    // Reset asserted during HOLD
    fetch1(64'h600, 32'h6666_0004);
    @(negedge clk);
    pc_in = 64'h604; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; stall = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_0005;
    @(negedge clk);
    imem_rsp_valid = 1'b0; reset = 1'b0;
    #1;
    chk("hold_pre_rst_valid", if_id_valid, 1);
    chk("hold_pre_rst_pc", if_id_pc, 64'h600);
    chk("in_rst_req_valid", imem_req_valid, 0);
    chk("in_rst_pc_stall", pc_stall, 1);
    @(negedge clk);
    #1;
    chk("hold_rst_valid", if_id_valid, 0);
    chk("hold_rst_pc", if_id_pc, 0);
    chk("hold_rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    chk("hold_rst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0;
    #1;
    chk("after_rst_req", imem_req_valid, 1);
    chk("after_rst_addr", imem_req_addr, 64'h604);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
